tlb_fill_ctrl: RTL and testbench
================================

TLB_FILL_CTRL -- requirements
Module: tlb_fill_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- TLB_ENTRIES, 4: fully associative entries; legal range 2..8.
- TIMEOUT_CYCLES, 16: maximum wait cycles for page-table completion; legal range 1..31.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- TRANS_REQ, in, 1: translation request from the core.
- TRANS_VPN, in, 4: virtual page number to translate.
- TRANS_READY, out, 1: block can accept TRANS_REQ this cycle.
- TRANS_VALID, out, 1: one-cycle response strobe.
- TRANS_HIT, out, 1: response came from a TLB hit.
- TRANS_FAULT, out, 1: response is a fault (timeout or tag mismatch).
- TRANS_PPN, out, 4: physical page number; 0 when TRANS_FAULT=1.
- LOOKUP_RQST, out, 1: page-table walk request.
- LOOKUP_ADDR, out, 4: VPN sent to the page table.
- LOOKUP_COMPLETE, in, 1: page table has a result.
- LOOKUP_RETURN, in, 8: page-table entry; [7:4] is the VPN tag, [3:0] is the PPN.
- FLUSH, in, 1: invalidate all entries; present only with TLB_FLUSH_EN.

Function
REQ-003 Each entry SHALL hold valid, vpn[3:0] and ppn[3:0]; a round-robin victim pointer SHALL range from 0 to TLB_ENTRIES-1.
REQ-004 The FSM SHALL have the states IDLE, WAIT and RESP; TRANS_READY SHALL be 1 only in IDLE.
REQ-005 In IDLE, when TRANS_REQ=1, TRANS_VPN SHALL be latched and compared against all valid entries in the same cycle.
REQ-006 On a hit, the next cycle SHALL be RESP with TRANS_VALID=1, TRANS_HIT=1, TRANS_FAULT=0 and the matching PPN; hit latency is 1 cycle.
REQ-007 On a miss, the FSM SHALL go to WAIT with LOOKUP_RQST=1 and LOOKUP_ADDR=latched VPN, both registered.
REQ-008 LOOKUP_ADDR SHALL stay stable and LOOKUP_RQST SHALL stay high for the whole of WAIT.
REQ-009 WAIT SHALL count cycles, with the counter cleared on entry to WAIT.
REQ-010 If LOOKUP_COMPLETE=1 is sampled in WAIT and LOOKUP_RETURN[7:4] equals the latched VPN:
- write the entry {1, VPN, RETURN[3:0]} into the victim slot;
- go to RESP with TRANS_VALID=1, TRANS_HIT=0, TRANS_FAULT=0, TRANS_PPN=RETURN[3:0].
REQ-011 If LOOKUP_COMPLETE=1 is sampled and the tag mismatches, there SHALL be no fill, and RESP SHALL have TRANS_FAULT=1 and TRANS_PPN=0.
REQ-012 If the counter reaches TIMEOUT_CYCLES without LOOKUP_COMPLETE, there SHALL be no fill, and RESP SHALL have TRANS_FAULT=1 and TRANS_PPN=0.
REQ-013 LOOKUP_RQST SHALL drop at the same edge that leaves WAIT and SHALL remain low at least 2 cycles (RESP, then IDLE) before any new walk.
REQ-014 LOOKUP_COMPLETE SHALL be ignored outside WAIT.
REQ-015 Victim selection SHALL use the lowest-index invalid entry if one exists; otherwise it SHALL use the round-robin pointer, and the pointer SHALL then advance modulo TLB_ENTRIES, wrapping from TLB_ENTRIES-1 to 0.
REQ-016 RESP SHALL last exactly 1 cycle, then return to IDLE.
REQ-017 TRANS_VALID, TRANS_HIT and TRANS_FAULT SHALL be 0 outside RESP.
REQ-018 TRANS_REQ SHALL be ignored while TRANS_READY=0.
REQ-019 Duplicate VPN tags SHALL never be created, because a fill only follows a miss.

Reset
REQ-020 While rst_n=0, asynchronously:
- state=IDLE, all valid=0, victim pointer=0, counter=0;
- TRANS_VALID, TRANS_HIT, TRANS_FAULT, TRANS_PPN, LOOKUP_RQST and LOOKUP_ADDR all 0.
REQ-021 Reset during WAIT SHALL abort the walk and drop LOOKUP_RQST immediately; no response SHALL be issued.
REQ-022 The first request after rst_n rises SHALL be accepted on the first rising edge at which rst_n=1.

Configuration
REQ-023 Macro TLB_FLUSH_EN defined: FLUSH port exists, and FLUSH=1 SHALL clear all valid bits and the victim pointer at the next edge, in any state.
- FLUSH in the same cycle as a fill: flush wins and no entry is written.
- FLUSH during WAIT: the later fill is suppressed, but the response is still delivered.
- FLUSH coincident with an IDLE hit: that hit still responds.
REQ-024 Macro TLB_FLUSH_EN undefined: no FLUSH port and no flush logic; entries are invalidated only by reset.

Verification
REQ-025 Cold miss: reset, then TRANS_REQ with VPN=0x3; the page table completes with RETURN=0x3A after 4 cycles.
- Required: LOOKUP_RQST high 4 cycles, LOOKUP_ADDR=0x3.
- Then TRANS_VALID=1, TRANS_HIT=0, TRANS_PPN=0xA; entry 0 filled.
REQ-026 Hit: repeat VPN=0x3 -> TRANS_VALID one cycle after request, TRANS_HIT=1, TRANS_PPN=0xA, LOOKUP_RQST stays 0.
REQ-027 Replacement wrap: fill VPNs 0x1-0x4, then miss on 0x5, then 0x6.
- 0x5 replaces entry 0 and 0x6 replaces entry 1.
- A subsequent VPN=0x1 misses; VPN=0x3 hits.
REQ-028 Timeout: LOOKUP_COMPLETE held low -> after exactly 16 WAIT cycles: TRANS_FAULT=1, TRANS_PPN=0, LOOKUP_RQST=0, no fill.
REQ-029 Tag mismatch: VPN=0x7, RETURN=0x82 -> TRANS_FAULT=1, no fill; a repeated VPN=0x7 misses again.
REQ-030 Reset mid-walk: rst_n=0 during WAIT -> LOOKUP_RQST=0 asynchronously, no TRANS_VALID; with TLB_FLUSH_EN, FLUSH during WAIT -> response delivered, then the same VPN misses.

Source files
------------

// File: rtl/tlb_fill_ctrl.sv
// tlb_fill_ctrl: fully associative 4-bit-VPN TLB that serves hits in one cycle and fills misses
// with a single page-table walk. Define TLB_FLUSH_EN to add the FLUSH port and the flush logic.
module tlb_fill_ctrl #(
    parameter int TLB_ENTRIES    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TRANS_REQ,
    input  logic [3:0] TRANS_VPN,
    output logic       TRANS_READY,
    output logic       TRANS_VALID,
    output logic       TRANS_HIT,
    output logic       TRANS_FAULT,
    output logic [3:0] TRANS_PPN,
    output logic       LOOKUP_RQST,
    output logic [3:0] LOOKUP_ADDR,
    input  logic       LOOKUP_COMPLETE,
    input  logic [7:0] LOOKUP_RETURN
`ifdef TLB_FLUSH_EN
    ,
    input  logic       FLUSH
`endif
);

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [4:0]       LAST_WAIT = 5'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [TLB_ENTRIES-1:0] valid;
    logic [3:0]             tag_q [TLB_ENTRIES];
    logic [3:0]             ppn_q [TLB_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr;
    logic [4:0]             wait_cnt;

    logic                   hit_any;
    logic [3:0]             hit_ppn;
    logic                   have_free;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       victim;
    logic                   tag_ok;
    logic                   walk_ok;
    logic                   fill_en;

`ifdef TLB_FLUSH_EN
    logic                   flush_seen;
`endif

    assign TRANS_READY = (state == IDLE);

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        hit_any = 1'b0;
        hit_ppn = 4'h0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (valid[i] && (tag_q[i] == TRANS_VPN)) begin
                hit_any = 1'b1;
                hit_ppn = ppn_q[i];
            end
        end
    end

    // Scan downward so the lowest-index free slot is the one left standing.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        victim = have_free ? free_idx : rr_ptr;
    end

    assign tag_ok  = (LOOKUP_RETURN[7:4] == LOOKUP_ADDR);
    assign walk_ok = (state == WAIT) && LOOKUP_COMPLETE && tag_ok;

`ifdef TLB_FLUSH_EN
    assign fill_en = walk_ok && !FLUSH && !flush_seen;
`else
    assign fill_en = walk_ok;
`endif

    // NOTE: only the valid bits need reset; tag/ppn storage is never read while invalid,
    // so it lives in a reset-free block and maps onto plain storage.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim] <= LOOKUP_ADDR;
            ppn_q[victim] <= LOOKUP_RETURN[3:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees the
    // pre-edge values; a later assignment in the same block overrides an earlier one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid       <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            TRANS_VALID <= 1'b0;
            TRANS_HIT   <= 1'b0;
            TRANS_FAULT <= 1'b0;
            TRANS_PPN   <= 4'h0;
            LOOKUP_RQST <= 1'b0;
            LOOKUP_ADDR <= 4'h0;
`ifdef TLB_FLUSH_EN
            flush_seen  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (TRANS_REQ) begin
                        if (hit_any) begin
                            state       <= RESP;
                            TRANS_VALID <= 1'b1;
                            TRANS_HIT   <= 1'b1;
                            TRANS_FAULT <= 1'b0;
                            TRANS_PPN   <= hit_ppn;
                        end else begin
                            state       <= WAIT;
                            LOOKUP_RQST <= 1'b1;
                            LOOKUP_ADDR <= TRANS_VPN;
                            wait_cnt    <= '0;
                        end
                    end
                end

                WAIT: begin
                    if (LOOKUP_COMPLETE) begin
                        state       <= RESP;
                        LOOKUP_RQST <= 1'b0;
                        TRANS_VALID <= 1'b1;
                        TRANS_HIT   <= 1'b0;
                        TRANS_FAULT <= !tag_ok;
                        TRANS_PPN   <= tag_ok ? LOOKUP_RETURN[3:0] : 4'h0;
                        if (fill_en) begin
                            valid[victim] <= 1'b1;
                            if (!have_free) begin
                                rr_ptr <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
                            end
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state       <= RESP;
                        LOOKUP_RQST <= 1'b0;
                        TRANS_VALID <= 1'b1;
                        TRANS_HIT   <= 1'b0;
                        TRANS_FAULT <= 1'b1;
                        TRANS_PPN   <= 4'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 5'd1;
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    TRANS_VALID <= 1'b0;
                    TRANS_HIT   <= 1'b0;
                    TRANS_FAULT <= 1'b0;
                    TRANS_PPN   <= 4'h0;
                end

                default: state <= IDLE;
            endcase

`ifdef TLB_FLUSH_EN
            // Flush overrides any fill written above; a flush seen during a walk blocks its fill.
            if (FLUSH) begin
                valid  <= '0;
                rr_ptr <= '0;
            end
            if (state == IDLE) begin
                flush_seen <= FLUSH;
            end else if (state == WAIT) begin
                flush_seen <= flush_seen | FLUSH;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// tb_tlb_fill_ctrl: directed self-checking bench for tlb_fill_ctrl (flush scenario
// is included when TLB_FLUSH_EN is defined).
module tb_tlb_fill_ctrl;

    logic       clk;
    logic       rst_n;
    logic       trans_req;
    logic [3:0] trans_vpn;
    logic       trans_ready;
    logic       trans_valid;
    logic       trans_hit;
    logic       trans_fault;
    logic [3:0] trans_ppn;
    logic       lookup_rqst;
    logic [3:0] lookup_addr;
    logic       lookup_complete;
    logic [7:0] lookup_return;
`ifdef TLB_FLUSH_EN
    logic       flush_in;
`endif

    int checks   = 0;
    int failures = 0;

    // Observations captured by probe().
    int         rq_cycles;
    logic       addr_ok;
    logic       o_v;
    logic       o_h;
    logic       o_f;
    logic [3:0] o_ppn;
    logic       o_ready_resp;
    logic       o_v_after;

    tlb_fill_ctrl #(
        .TLB_ENTRIES    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .TRANS_REQ       (trans_req),
        .TRANS_VPN       (trans_vpn),
        .TRANS_READY     (trans_ready),
        .TRANS_VALID     (trans_valid),
        .TRANS_HIT       (trans_hit),
        .TRANS_FAULT     (trans_fault),
        .TRANS_PPN       (trans_ppn),
        .LOOKUP_RQST     (lookup_rqst),
        .LOOKUP_ADDR     (lookup_addr),
        .LOOKUP_COMPLETE (lookup_complete),
        .LOOKUP_RETURN   (lookup_return)
`ifdef TLB_FLUSH_EN
        ,
        .FLUSH           (flush_in)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at posedge+1; returns at posedge+1 with rst_n just released.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n           = 1'b0;
        trans_req       = 1'b0;
        trans_vpn       = 4'h0;
        lookup_complete = 1'b0;
        lookup_return   = 8'h00;
`ifdef TLB_FLUSH_EN
        flush_in        = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One transaction: request vpn; if a walk starts, answer with ret in WAIT cycle done_at
    // (0 = never). Walk length is bounded at 40 cycles.
    task automatic probe(input logic [3:0] vpn, input int done_at, input logic [7:0] ret);
        trans_vpn = vpn;
        trans_req = 1'b1;
        @(posedge clk); #1;
        trans_req = 1'b0;
        rq_cycles = 0;
        addr_ok   = 1'b1;
        for (int c = 1; c <= 40 && lookup_rqst === 1'b1; c++) begin
            rq_cycles = c;
            if (lookup_addr !== vpn) addr_ok = 1'b0;
            if (c == done_at) begin
                lookup_complete = 1'b1;
                lookup_return   = ret;
            end
            @(posedge clk); #1;
            lookup_complete = 1'b0;
        end
        o_v          = trans_valid;
        o_h          = trans_hit;
        o_f          = trans_fault;
        o_ppn        = trans_ppn;
        o_ready_resp = trans_ready;
        @(posedge clk); #1;
        o_v_after    = trans_valid;
    endtask

    task automatic test_reset();
        rst_n           = 1'b1;
        trans_req       = 1'b0;
        trans_vpn       = 4'h0;
        lookup_complete = 1'b0;
        lookup_return   = 8'h00;
`ifdef TLB_FLUSH_EN
        flush_in        = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({trans_valid, trans_hit, trans_fault, lookup_rqst} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {trans_valid, trans_hit, trans_fault, lookup_rqst});
        end
        checks++; if ({trans_ppn, lookup_addr} !== 8'h00) begin
            failures++; $display("FAIL reset_ppn_addr got=%h exp=00", {trans_ppn, lookup_addr});
        end
        checks++; if (trans_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", trans_ready);
        end
    endtask

    task automatic test_cold_miss();
        apply_reset();
        probe(4'h3, 4, 8'h3A);
        checks++; if (rq_cycles !== 4) begin
            failures++; $display("FAIL cold_rqst_cycles got=%0d exp=4", rq_cycles);
        end
        checks++; if (addr_ok !== 1'b1) begin
            failures++; $display("FAIL cold_lookup_addr got=unstable exp=3");
        end
        checks++; if ({o_v, o_h, o_f} !== 3'b100) begin
            failures++; $display("FAIL cold_resp_flags got=%b exp=100", {o_v, o_h, o_f});
        end
        checks++; if (o_ppn !== 4'hA) begin
            failures++; $display("FAIL cold_ppn got=%h exp=a", o_ppn);
        end
        checks++; if ({o_ready_resp, o_v_after} !== 2'b00) begin
            failures++; $display("FAIL cold_resp_one_cycle got=%b exp=00", {o_ready_resp, o_v_after});
        end
    endtask

    task automatic test_hit();
        probe(4'h3, 0, 8'h00);
        checks++; if (rq_cycles !== 0) begin
            failures++; $display("FAIL hit_no_walk got=%0d exp=0", rq_cycles);
        end
        checks++; if ({o_v, o_h, o_f, o_ppn} !== 7'b110_1010) begin
            failures++; $display("FAIL hit_resp got=%b exp=1101010", {o_v, o_h, o_f, o_ppn});
        end
        checks++; if (o_v_after !== 1'b0) begin
            failures++; $display("FAIL hit_valid_after got=%b exp=0", o_v_after);
        end
    endtask

    task automatic test_replacement();
        logic [3:0] hv [4] = '{4'h3, 4'h4, 4'h5, 4'h6};
        logic [3:0] hp [4] = '{4'hB, 4'hC, 4'hD, 4'hE};
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            probe(4'(i), 1, {4'(i), 4'(i + 8)});
            checks++; if ({rq_cycles == 1, o_f, o_ppn} !== {1'b1, 1'b0, 4'(i + 8)}) begin
                failures++; $display("FAIL fill_%0d got=rq%0d f%b ppn%h exp=rq1 f0 ppn%h", i, rq_cycles, o_f, o_ppn, 4'(i + 8));
            end
        end
        probe(4'h5, 1, 8'h5D);
        probe(4'h6, 1, 8'h6E);
        for (int i = 0; i < 4; i++) begin
            probe(hv[i], 0, 8'h00);
            checks++; if ({rq_cycles == 0, o_h, o_ppn} !== {2'b11, hp[i]}) begin
                failures++; $display("FAIL repl_hit_%h got=rq%0d h%b ppn%h exp=rq0 h1 ppn%h", hv[i], rq_cycles, o_h, o_ppn, hp[i]);
            end
        end
        probe(4'h1, 1, 8'hF0);
        checks++; if ({rq_cycles == 1, o_f} !== 2'b11) begin
            failures++; $display("FAIL repl_evicted_1 got=rq%0d f%b exp=rq1 f1", rq_cycles, o_f);
        end
        probe(4'h7, 1, 8'h71);
        probe(4'h8, 1, 8'h82);
        probe(4'h9, 1, 8'h93);
        probe(4'h6, 0, 8'h00);
        checks++; if ({rq_cycles == 0, o_h, o_ppn} !== 6'b11_1110) begin
            failures++; $display("FAIL wrap_keep_6 got=rq%0d h%b ppn%h exp=rq0 h1 ppne", rq_cycles, o_h, o_ppn);
        end
        probe(4'h9, 0, 8'h00);
        checks++; if ({rq_cycles == 0, o_h, o_ppn} !== 6'b11_0011) begin
            failures++; $display("FAIL wrap_hit_9 got=rq%0d h%b ppn%h exp=rq0 h1 ppn3", rq_cycles, o_h, o_ppn);
        end
        probe(4'h5, 1, 8'hF0);
        checks++; if (rq_cycles !== 1) begin
            failures++; $display("FAIL wrap_evicted_5 got=rq%0d exp=rq1", rq_cycles);
        end
    endtask

    task automatic test_timeout();
        probe(4'hB, 0, 8'h00);
        checks++; if (rq_cycles !== 16) begin
            failures++; $display("FAIL timeout_cycles got=%0d exp=16", rq_cycles);
        end
        checks++; if ({o_v, o_h, o_f, o_ppn} !== 7'b101_0000) begin
            failures++; $display("FAIL timeout_resp got=%b exp=1010000", {o_v, o_h, o_f, o_ppn});
        end
        probe(4'hB, 1, 8'hB5);
        checks++; if ({rq_cycles == 1, o_f, o_ppn} !== 6'b10_0101) begin
            failures++; $display("FAIL timeout_no_fill got=rq%0d f%b ppn%h exp=rq1 f0 ppn5", rq_cycles, o_f, o_ppn);
        end
    endtask

    task automatic test_mismatch();
        apply_reset();
        probe(4'h7, 1, 8'h82);
        checks++; if ({o_v, o_h, o_f, o_ppn} !== 7'b101_0000) begin
            failures++; $display("FAIL mismatch_resp got=%b exp=1010000", {o_v, o_h, o_f, o_ppn});
        end
        // Stray completion while idle must be ignored.
        lookup_complete = 1'b1;
        lookup_return   = 8'h79;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if ({trans_valid, lookup_rqst} !== 2'b00) begin
                failures++; $display("FAIL idle_complete_ignored got=%b exp=00", {trans_valid, lookup_rqst});
            end
        end
        lookup_complete = 1'b0;
        probe(4'h7, 2, 8'h82);
        checks++; if ({rq_cycles == 2, o_f} !== 2'b11) begin
            failures++; $display("FAIL mismatch_remiss got=rq%0d f%b exp=rq2 f1", rq_cycles, o_f);
        end
    endtask

    task automatic test_back_to_back();
        trans_vpn = 4'hC;
        trans_req = 1'b1;
        @(posedge clk); #1;
        trans_vpn = 4'hD;
        checks++; if ({lookup_rqst, lookup_addr, trans_ready} !== 6'b1_1100_0) begin
            failures++; $display("FAIL b2b_wait_entry got=%b exp=111000", {lookup_rqst, lookup_addr, trans_ready});
        end
        @(posedge clk); #1;
        checks++; if (lookup_addr !== 4'hC) begin
            failures++; $display("FAIL b2b_req_ignored got=%h exp=c", lookup_addr);
        end
        lookup_complete = 1'b1;
        lookup_return   = 8'hC5;
        @(posedge clk); #1;
        lookup_complete = 1'b0;
        checks++; if ({trans_valid, trans_ppn, lookup_rqst, trans_ready} !== 7'b1_0101_00) begin
            failures++; $display("FAIL b2b_resp_c got=%b exp=1010100", {trans_valid, trans_ppn, lookup_rqst, trans_ready});
        end
        @(posedge clk); #1;
        checks++; if ({trans_valid, lookup_rqst, trans_ready} !== 3'b001) begin
            failures++; $display("FAIL b2b_idle_gap got=%b exp=001", {trans_valid, lookup_rqst, trans_ready});
        end
        @(posedge clk); #1;
        trans_req = 1'b0;
        checks++; if ({lookup_rqst, lookup_addr} !== 5'b1_1101) begin
            failures++; $display("FAIL b2b_second_walk got=%b exp=11101", {lookup_rqst, lookup_addr});
        end
        lookup_complete = 1'b1;
        lookup_return   = 8'hD6;
        @(posedge clk); #1;
        lookup_complete = 1'b0;
        checks++; if ({trans_valid, trans_hit, trans_ppn} !== 6'b10_0110) begin
            failures++; $display("FAIL b2b_resp_d got=%b exp=100110", {trans_valid, trans_hit, trans_ppn});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_walk();
        trans_vpn = 4'hE;
        trans_req = 1'b1;
        @(posedge clk); #1;
        trans_req = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({lookup_rqst, trans_valid, trans_ready} !== 3'b001) begin
            failures++; $display("FAIL midwalk_async_abort got=%b exp=001", {lookup_rqst, trans_valid, trans_ready});
        end
        #1 rst_n = 1'b1;
        lookup_complete = 1'b1;
        lookup_return   = 8'hE1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({trans_valid, lookup_rqst} !== 2'b00) begin
                failures++; $display("FAIL midwalk_no_resp got=%b exp=00", {trans_valid, lookup_rqst});
            end
        end
        lookup_complete = 1'b0;
        probe(4'hE, 1, 8'hE1);
        checks++; if ({rq_cycles == 1, o_v, o_h, o_ppn} !== 7'b110_0001) begin
            failures++; $display("FAIL midwalk_retry got=rq%0d v%b h%b ppn%h exp=rq1 v1 h0 ppn1", rq_cycles, o_v, o_h, o_ppn);
        end
    endtask

`ifdef TLB_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        probe(4'h2, 1, 8'h27);
        probe(4'h2, 0, 8'h00);
        checks++; if ({rq_cycles == 0, o_h, o_ppn} !== 6'b11_0111) begin
            failures++; $display("FAIL flush_pre_hit got=rq%0d h%b ppn%h exp=rq0 h1 ppn7", rq_cycles, o_h, o_ppn);
        end
        trans_vpn = 4'h3;
        trans_req = 1'b1;
        @(posedge clk); #1;
        trans_req = 1'b0;
        flush_in  = 1'b1;
        @(posedge clk); #1;
        flush_in        = 1'b0;
        lookup_complete = 1'b1;
        lookup_return   = 8'h3B;
        @(posedge clk); #1;
        lookup_complete = 1'b0;
        checks++; if ({trans_valid, trans_hit, trans_fault, trans_ppn} !== 7'b100_1011) begin
            failures++; $display("FAIL flush_resp got=%b exp=1001011", {trans_valid, trans_hit, trans_fault, trans_ppn});
        end
        @(posedge clk); #1;
        probe(4'h2, 1, 8'hF0);
        checks++; if (rq_cycles !== 1) begin
            failures++; $display("FAIL flush_cleared_2 got=rq%0d exp=rq1", rq_cycles);
        end
        probe(4'h3, 1, 8'hF0);
        checks++; if (rq_cycles !== 1) begin
            failures++; $display("FAIL flush_no_fill_3 got=rq%0d exp=rq1", rq_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_replacement();
        test_timeout();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_walk();
`ifdef TLB_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
